meas_seq_ctrl: RTL and testbench

MEAS_SEQ_CTRL -- requirements
Module: meas_seq_ctrl

---
 rtl/meas_seq_ctrl_if.sv | 22 ++
 rtl/meas_seq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_meas_seq_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/meas_seq_ctrl_if.sv
// Shared-memory request/grant bundle between the samplers/MCU side and the
// measurement sequencer; master = requesters, slave = sequencer/arbiter.
interface meas_seq_ctrl_if;
   logic        wr_req;
   logic [15:0] wr_off;
   logic        wr_gnt;
   logic        rd_req;
   logic [19:0] rd_addr;
   logic        rd_gnt;
   logic [19:0] mem_addr;
   logic        mem_we;

   modport master (
      output wr_req, wr_off, rd_req, rd_addr,
      input  wr_gnt, rd_gnt, mem_addr, mem_we
   );

   modport slave (
      input  wr_req, wr_off, rd_req, rd_addr,
      output wr_gnt, rd_gnt, mem_addr, mem_we
   );
endinterface

// File: rtl/meas_seq_ctrl.sv
// Measurement run sequencer: steps channels on cycle-sync edges and arbitrates
// sampler writes (into per-channel regions) against MCU reads of shared memory.
module meas_seq_ctrl #(
   parameter int MAX_CH      = 25,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              mcu_n_rst,
   input  logic              mcu_start,
   input  logic              ch_sync_in,
   meas_seq_ctrl_if.slave    bus,
   output logic [4:0]        ch_idx,
   output logic              sample_en,
   output logic              mcu_end,
   output logic              ovf
);

   localparam logic [19:0] IDLE_ADDR = 20'h7FFF0;
   localparam logic [4:0]  LAST_CH   = 5'(MAX_CH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Bit 0 = mcu_start, bit 1 = ch_sync_in
   logic [1:0] async_in;
   logic [1:0] rise;

   assign async_in = {ch_sync_in, mcu_start};

   // Each chain holds SYNC_STAGES synchronizer flops plus a top delayed copy for edge detect
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_sync
         logic [SYNC_STAGES:0] chain_reg;
         always_ff @(posedge clk or negedge mcu_n_rst) begin
            if (!mcu_n_rst) begin
               chain_reg <= '0;
            end else begin
               chain_reg <= {chain_reg[SYNC_STAGES-1:0], async_in[gi]};
            end
         end
         assign rise[gi] = chain_reg[SYNC_STAGES-1] & ~chain_reg[SYNC_STAGES];
      end
   endgenerate

   logic start_rise;
   logic sync_rise;
   assign start_rise = rise[0];
   assign sync_rise  = rise[1];

   function automatic logic [19:0] region_base(input logic [4:0] ch);
      logic [19:0] n;
      n = 20'(ch);
      if (ch <= 5'd9)
         return (n - 20'd1) << 12;
      else if (ch <= 5'd13)
         return 20'h09000 + ((n - 20'd10) << 16);
      else
         return 20'h49000 + ((n - 20'd14) << 12);
   endfunction

   state_t      state_reg, state_next;
   logic [4:0]  ch_idx_reg, ch_idx_next;
   logic        sample_en_reg, sample_en_next;
   logic        mcu_end_reg, mcu_end_next;
   logic        ovf_reg, ovf_next;
   logic        wr_gnt_reg, wr_gnt_next;
   logic        rd_gnt_reg, rd_gnt_next;
   logic        mem_we_reg, mem_we_next;
   logic [19:0] mem_addr_reg, mem_addr_next;

   logic        wr_ok;
   logic        rd_ok;
   logic        wr_ovf;
   logic        big_region;
   logic [19:0] wr_base;

   always_comb begin
      state_next     = state_reg;
      ch_idx_next    = ch_idx_reg;
      sample_en_next = sample_en_reg;
      mcu_end_next   = mcu_end_reg;
      ovf_next       = ovf_reg;
      wr_gnt_next    = 1'b0;
      rd_gnt_next    = 1'b0;
      mem_we_next    = 1'b0;
      mem_addr_next  = IDLE_ADDR;

      // A requester just granted is still holding its request this cycle, so skip it
      wr_ok      = bus.wr_req && (state_reg == RUN) && (ch_idx_reg != 5'd0) && !wr_gnt_reg;
      rd_ok      = bus.rd_req && !rd_gnt_reg;
      big_region = (ch_idx_reg >= 5'd10) && (ch_idx_reg <= 5'd13);
      wr_ovf     = !big_region && (bus.wr_off[15:12] != 4'h0);
      wr_base    = region_base(ch_idx_reg);

      case (state_reg)
         IDLE, DONE: begin
            if (start_rise) begin
               state_next     = RUN;
               ch_idx_next    = 5'd0;
               sample_en_next = 1'b1;
               mcu_end_next   = 1'b0;
               ovf_next       = 1'b0;
            end
         end
         RUN: begin
            if (sync_rise) begin
               if (ch_idx_reg == LAST_CH) begin
                  state_next     = DONE;
                  ch_idx_next    = 5'd0;
                  sample_en_next = 1'b0;
                  mcu_end_next   = 1'b1;
               end else begin
                  ch_idx_next = ch_idx_reg + 5'd1;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      // Writes use the pre-increment channel; an out-of-region offset is consumed but dropped
      if (wr_ok) begin
         wr_gnt_next = 1'b1;
         if (wr_ovf) begin
            mem_addr_next = mem_addr_reg;
            ovf_next      = 1'b1;
         end else begin
            mem_we_next   = 1'b1;
            mem_addr_next = wr_base + {4'h0, bus.wr_off};
         end
      end else if (rd_ok) begin
         rd_gnt_next   = 1'b1;
         mem_addr_next = bus.rd_addr;
      end
   end

   always_ff @(posedge clk or negedge mcu_n_rst) begin
      if (!mcu_n_rst) begin
         state_reg     <= IDLE;
         ch_idx_reg    <= 5'd0;
         sample_en_reg <= 1'b0;
         mcu_end_reg   <= 1'b0;
         ovf_reg       <= 1'b0;
         wr_gnt_reg    <= 1'b0;
         rd_gnt_reg    <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= IDLE_ADDR;
      end else begin
         state_reg     <= state_next;
         ch_idx_reg    <= ch_idx_next;
         sample_en_reg <= sample_en_next;
         mcu_end_reg   <= mcu_end_next;
         ovf_reg       <= ovf_next;
         wr_gnt_reg    <= wr_gnt_next;
         rd_gnt_reg    <= rd_gnt_next;
         mem_we_reg    <= mem_we_next;
         mem_addr_reg  <= mem_addr_next;
      end
   end

   assign ch_idx       = ch_idx_reg;
   assign sample_en    = sample_en_reg;
   assign mcu_end      = mcu_end_reg;
   assign ovf          = ovf_reg;
   assign bus.wr_gnt   = wr_gnt_reg;
   assign bus.rd_gnt   = rd_gnt_reg;
   assign bus.mem_we   = mem_we_reg;
   assign bus.mem_addr = mem_addr_reg;

endmodule

// File: tb/tb_meas_seq_ctrl.sv
// Scoreboard bench for meas_seq_ctrl: requester tasks queue expected grants,
// a negedge monitor pops and compares every grant and checks the idle bus.
module tb_meas_seq_ctrl;

   logic       clk;
   logic       mcu_n_rst;
   logic       mcu_start;
   logic       ch_sync_in;
   logic [4:0] ch_idx;
   logic       sample_en;
   logic       mcu_end;
   logic       ovf;

   meas_seq_ctrl_if bus ();

   meas_seq_ctrl #(.MAX_CH(25), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .mcu_n_rst  (mcu_n_rst),
      .mcu_start  (mcu_start),
      .ch_sync_in (ch_sync_in),
      .bus        (bus.slave),
      .ch_idx     (ch_idx),
      .sample_en  (sample_en),
      .mcu_end    (mcu_end),
      .ovf        (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          is_wr;
      logic [19:0] addr;
      bit          we;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;

   // Monitor: every grant must match the head of the queue; non-grant cycles park the bus
   always @(negedge clk) begin
      n_cmp++;
      if (bus.wr_gnt || bus.rd_gnt) begin
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_grant: wr_gnt=%0b rd_gnt=%0b addr=%05h we=%0b, required no grant",
                     bus.wr_gnt, bus.rd_gnt, bus.mem_addr, bus.mem_we);
         end else begin
            mon_e = exp_q.pop_front();
            if (bus.wr_gnt !== mon_e.is_wr || bus.rd_gnt !== !mon_e.is_wr ||
                bus.mem_addr !== mon_e.addr || bus.mem_we !== mon_e.we) begin
               n_bad++;
               $display("FAIL grant: wr_gnt=%0b rd_gnt=%0b addr=%05h we=%0b, required %s addr=%05h we=%0b",
                        bus.wr_gnt, bus.rd_gnt, bus.mem_addr, bus.mem_we,
                        mon_e.is_wr ? "wr" : "rd", mon_e.addr, mon_e.we);
            end else begin
               $display("txn %s addr=%05h we=%0b ch=%0d t=%0t",
                        mon_e.is_wr ? "wr" : "rd", bus.mem_addr, bus.mem_we, ch_idx, $time);
            end
         end
      end else if (bus.mem_we !== 1'b0 || bus.mem_addr !== 20'h7FFF0) begin
         n_bad++;
         $display("FAIL idle_bus: addr=%05h we=%0b, required addr=7fff0 we=0 t=%0t",
                  bus.mem_addr, bus.mem_we, $time);
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      mcu_start = 1'b1;
      cyc(4);
      mcu_start = 1'b0;
      cyc(4);
   endtask

   task automatic pulse_sync();
      ch_sync_in = 1'b1;
      cyc(4);
      ch_sync_in = 1'b0;
      cyc(4);
   endtask

   // Requester holds wr_req through the grant cycle, like a registered sampler
   task automatic do_write(input logic [15:0] off, input int exp_lat);
      int lat;
      lat = 0;
      bus.wr_off = off;
      bus.wr_req = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         cyc(1);
         if (bus.wr_gnt) begin
            lat = i;
            break;
         end
      end
      check("wr_latency", lat, exp_lat);
      cyc(1);
      bus.wr_req = 1'b0;
   endtask

   task automatic do_read(input logic [19:0] addr, input int exp_lat);
      int lat;
      lat = 0;
      bus.rd_addr = addr;
      bus.rd_req  = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         cyc(1);
         if (bus.rd_gnt) begin
            lat = i;
            break;
         end
      end
      check("rd_latency", lat, exp_lat);
      cyc(1);
      bus.rd_req = 1'b0;
   endtask

   task automatic wr_blocked(input string name, input int n);
      bit got;
      got = 1'b0;
      bus.wr_off = 16'h0004;
      bus.wr_req = 1'b1;
      for (int i = 0; i < n; i++) begin
         cyc(1);
         if (bus.wr_gnt) got = 1'b1;
      end
      check(name, got, 0);
      bus.wr_req = 1'b0;
   endtask

   task automatic push(input bit is_wr, input logic [19:0] addr, input bit we);
      exp_t e;
      e.is_wr = is_wr;
      e.addr  = addr;
      e.we    = we;
      exp_q.push_back(e);
   endtask

   initial begin
      mcu_n_rst   = 1'b1;
      mcu_start   = 1'b0;
      ch_sync_in  = 1'b0;
      bus.wr_req  = 1'b0;
      bus.wr_off  = 16'h0000;
      bus.rd_req  = 1'b0;
      bus.rd_addr = 20'h00000;
      #2 mcu_n_rst = 1'b0;
      #1;
      check("rst_ch_idx", ch_idx, 0);
      check("rst_sample_en", sample_en, 0);
      check("rst_mcu_end", mcu_end, 0);
      check("rst_ovf", ovf, 0);
      check("rst_gnts", {bus.wr_gnt, bus.rd_gnt}, 0);
      check("rst_mem", {bus.mem_we, bus.mem_addr}, 21'h07FFF0);
      cyc(3);
      mcu_n_rst = 1'b1;
      cyc(2);

      // IDLE: reads allowed, writes and sync edges ignored
      push(1'b0, 20'h12345, 1'b0);
      do_read(20'h12345, 1);
      pulse_sync();
      check("idle_sync_ignored", ch_idx, 0);
      wr_blocked("idle_wr_blocked", 5);

      pulse_start();
      check("start_sample_en", sample_en, 1);
      check("start_ch_idx", ch_idx, 0);
      check("start_mcu_end", mcu_end, 0);
      wr_blocked("ch0_wr_blocked", 5);

      for (int n = 1; n <= 25; n++) begin
         if (n == 15) begin
            // Write sampled on the same edge as the sync edge lands in the old channel (14)
            push(1'b1, 20'h49ABC, 1'b1);
            fork
               pulse_sync();
               begin
                  cyc(2);
                  do_write(16'h0ABC, 1);
               end
            join
         end else begin
            pulse_sync();
         end
         check("ch_step", ch_idx, n);
         case (n)
            1: begin
               push(1'b1, 20'h00FFF, 1'b1);
               do_write(16'h0FFF, 1);
            end
            2: begin
               push(1'b1, 20'h01010, 1'b1);
               push(1'b0, 20'hABCDE, 1'b0);
               fork
                  do_write(16'h0010, 1);
                  do_read(20'hABCDE, 2);
               join
            end
            4: begin
               push(1'b1, 20'h7FFF0, 1'b0);
               do_write(16'h1000, 1);
               check("ovf_set", ovf, 1);
            end
            5: begin
               pulse_start();
               check("run_start_ignored_ch", ch_idx, 5);
               check("run_start_ignored_ovf", ovf, 1);
               check("run_start_ignored_en", sample_en, 1);
            end
            9: begin
               push(1'b1, 20'h08800, 1'b1);
               do_write(16'h0800, 1);
            end
            10: begin
               push(1'b1, 20'h0A000, 1'b1);
               do_write(16'h1000, 1);
            end
            11: begin
               push(1'b1, 20'h19123, 1'b1);
               do_write(16'h0123, 1);
            end
            13: begin
               push(1'b1, 20'h48FFF, 1'b1);
               do_write(16'hFFFF, 1);
            end
            14: begin
               push(1'b1, 20'h49000, 1'b1);
               do_write(16'h0000, 1);
            end
            25: begin
               push(1'b1, 20'h54FFF, 1'b1);
               do_write(16'h0FFF, 1);
            end
            default: ;
         endcase
      end

      // Final edge: sample_en must fall in the very cycle mcu_end rises
      ch_sync_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc(1);
         check("en_end_exclusive", sample_en ^ mcu_end, 1);
         if (i == 3) ch_sync_in = 1'b0;
      end
      check("done_ch_idx", ch_idx, 0);
      check("done_mcu_end", mcu_end, 1);
      check("done_sample_en", sample_en, 0);
      check("done_ovf_held", ovf, 1);

      pulse_sync();
      check("done_sync_ignored", ch_idx, 0);
      wr_blocked("done_wr_blocked", 5);
      push(1'b0, 20'h7FFFF, 1'b0);
      do_read(20'h7FFFF, 1);

      pulse_start();
      check("restart_ovf_clr", ovf, 0);
      check("restart_mcu_end", mcu_end, 0);
      check("restart_sample_en", sample_en, 1);

      for (int n = 1; n <= 7; n++) begin
         pulse_sync();
         if (n == 5) begin
            push(1'b1, 20'h7FFF0, 1'b0);
            do_write(16'h2000, 1);
         end
      end
      check("pre_rst_ch_idx", ch_idx, 7);
      check("pre_rst_ovf", ovf, 1);

      // Reset mid-run with a write pending
      bus.wr_off = 16'h0020;
      bus.wr_req = 1'b1;
      #2 mcu_n_rst = 1'b0;
      #1;
      check("midrst_ch_idx", ch_idx, 0);
      check("midrst_flags", {sample_en, mcu_end, ovf}, 0);
      check("midrst_gnts", {bus.wr_gnt, bus.rd_gnt}, 0);
      check("midrst_mem", {bus.mem_we, bus.mem_addr}, 21'h07FFF0);
      cyc(3);
      check("midrst_no_gnt", bus.wr_gnt, 0);
      mcu_n_rst = 1'b1;
      wr_blocked("post_rst_wr_blocked", 5);
      pulse_sync();
      pulse_sync();
      check("post_rst_ch_idx", ch_idx, 0);
      check("post_rst_sample_en", sample_en, 0);
      push(1'b0, 20'h00042, 1'b0);
      do_read(20'h00042, 1);

      cyc(3);
      check("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
